// File: rtl/mem_access_unit_if.sv
// Request/response and dataMem bus of the byte-addressed load/store unit.
// The slave modport is the unit itself; master is the CPU/memory side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for word-indexed dataMem; sub-word
// stores are done as read-modify-write, loads are lane-selected and extended.
module mem_access_unit #(
    parameter logic [31:0] IO_BASE = 32'hFFFF0000
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic        signed_reg;
    logic [1:0]  size_reg;
    logic [1:0]  off_reg;
    logic [15:0] wdata_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wd_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        accept;
    logic        req_io;
    logic        req_err;
    logic [31:0] req_word_addr;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic [31:0] shifted;
    logic [15:0] half_sel;

    assign accept = (state_reg == IDLE) && bus.req_valid;
    assign req_io = (bus.req_addr[31:16] == IO_BASE[31:16]);

    // Sub-word accesses are not supported by the I/O port.
    assign req_err = (bus.req_size == 2'b11)
                  || ((bus.req_size == 2'b01) && bus.req_addr[0])
                  || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
                  || ((bus.req_size != 2'b10) && req_io);

    assign req_word_addr = req_io ? {bus.req_addr[31:16], 2'b00, bus.req_addr[15:2]}
                                  : {2'b00, bus.req_addr[31:2]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = req_err ? DONE : ACCESS;
            ACCESS:  state_next = (we_reg && (size_reg != 2'b10)) ? MERGE : DONE;
            MERGE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign shifted  = bus.mem_rd >> {off_reg, 3'b000};
    assign half_sel = off_reg[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

    always_comb begin
        load_data = bus.mem_rd;
        case (size_reg)
            2'b00:   load_data = {{24{signed_reg & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{signed_reg & half_sel[15]}}, half_sel};
            default: load_data = bus.mem_rd;
        endcase
    end

    // Per byte lane: take store data if the lane is targeted, else keep memory.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_hit;
            logic [7:0] lane_byte;
            assign lane_hit  = (size_reg == 2'b00) ? (off_reg == LANE)
                                                   : (off_reg[1] == LANE[1]);
            assign lane_byte = (size_reg == 2'b00) ? wdata_reg[7:0]
                                                   : wdata_reg[8*(gi%2) +: 8];
            assign merged[8*gi +: 8] = lane_hit ? lane_byte : bus.mem_rd[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            signed_reg   <= 1'b0;
            size_reg     <= 2'b00;
            off_reg      <= 2'b00;
            wdata_reg    <= '0;
            mem_addr_reg <= '0;
            mem_wd_reg   <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg     <= bus.req_we;
                        signed_reg <= bus.req_signed;
                        size_reg   <= bus.req_size;
                        off_reg    <= bus.req_addr[1:0];
                        wdata_reg  <= bus.req_wdata[15:0];
                        rdata_reg  <= '0;
                        err_reg    <= req_err;
                        if (!req_err) begin
                            mem_addr_reg <= req_word_addr;
                            if (bus.req_we && (bus.req_size == 2'b10))
                                mem_wd_reg <= bus.req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_reg)
                        rdata_reg <= load_data;
                    else if (size_reg != 2'b10)
                        mem_wd_reg <= merged;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.resp_valid = (state_reg == DONE);
    assign bus.resp_rdata = rdata_reg;
    assign bus.resp_err   = err_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wd     = mem_wd_reg;
    assign bus.mem_we     = !reset && (((state_reg == ACCESS) && we_reg && (size_reg == 2'b10))
                                       || (state_reg == MERGE));
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: driver pushes expected responses/writes,
// a negedge monitor pops and compares them against the DUT.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit_if bus ();

    mem_access_unit #(.IO_BASE(32'hFFFF0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // dataMem model: 256 RAM words plus two I/O words
    logic [31:0] ram [0:255];
    logic [31:0] io_out = 32'h0;
    logic [31:0] io_in  = 32'h0000CAFE;

    always_comb begin
        bus.mem_rd = 32'hDEADBEEF;
        if (bus.mem_addr == 32'hFFFF0001)
            bus.mem_rd = io_in;
        else if (bus.mem_addr == 32'hFFFF0000)
            bus.mem_rd = io_out;
        else if (bus.mem_addr[31:8] == 24'h0)
            bus.mem_rd = ram[bus.mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (bus.mem_we) begin
            if (bus.mem_addr == 32'hFFFF0000)
                io_out <= bus.mem_wd;
            else if (bus.mem_addr[31:8] == 24'h0)
                ram[bus.mem_addr[7:0]] <= bus.mem_wd;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    resp_t mon_r;
    wr_t   mon_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT completes or writes.
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: rdata %h err %b with no request pending", bus.resp_rdata, bus.resp_err);
            end else begin
                mon_r = resp_q.pop_front();
                chk("resp_rdata", bus.resp_rdata, mon_r.rdata);
                chk("resp_err", {31'b0, bus.resp_err}, {31'b0, mon_r.err});
                chk("latency", cyc - mon_r.acc + 1, mon_r.lat);
                $display("resp: rdata=%h err=%b latency=%0d", bus.resp_rdata, bus.resp_err, cyc - mon_r.acc + 1);
            end
        end
        if (bus.mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: mem_addr %h mem_wd %h with no write expected", bus.mem_addr, bus.mem_wd);
            end else begin
                mon_w = wr_q.pop_front();
                chk("mem_addr", bus.mem_addr, mon_w.addr);
                chk("mem_wd", bus.mem_wd, mon_w.data);
                $display("write: mem_addr=%h mem_wd=%h", bus.mem_addr, bus.mem_wd);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req_ready %b required 1", bus.req_ready);
        end
    endtask

    task automatic wait_resp();
        int n = 0;
        while (resp_q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (resp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: %0d responses outstanding, required 0", resp_q.size());
            resp_q.delete();
            wr_q.delete();
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input logic wr, input logic [31:0] waddr, input logic [31:0] wdata_exp);
        wait_ready();
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        resp_q.push_back('{exp_rdata, exp_err, exp_lat, cyc});
        if (wr) wr_q.push_back('{waddr, wdata_exp});
        // scramble the request fields to prove the unit latched them
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_size   = ~size;
        bus.req_signed = ~sgn;
        bus.req_addr   = 32'h0000_0FF1;
        bus.req_wdata  = ~wdata;
        wait_resp();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wd", bus.mem_wd, 32'h0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // word store / load
        do_req(1, 2'b10, 0, 32'h190, 32'h11223344, 32'h0, 0, 2, 1, 32'd100, 32'h11223344);
        do_req(0, 2'b10, 0, 32'h190, 32'h0, 32'h11223344, 0, 2, 0, 0, 0);
        // byte store via read-modify-write, then byte loads
        do_req(1, 2'b00, 0, 32'h191, 32'h000000AB, 32'h0, 0, 3, 1, 32'd100, 32'h1122AB44);
        do_req(0, 2'b00, 1, 32'h191, 32'h0, 32'hFFFFFFAB, 0, 2, 0, 0, 0);
        do_req(0, 2'b00, 0, 32'h191, 32'h0, 32'h000000AB, 0, 2, 0, 0, 0);
        // half store (upper wdata bits ignored), then half/byte loads
        do_req(1, 2'b01, 0, 32'h192, 32'h55558001, 32'h0, 0, 3, 1, 32'd100, 32'h8001AB44);
        do_req(0, 2'b01, 1, 32'h192, 32'h0, 32'hFFFF8001, 0, 2, 0, 0, 0);
        do_req(0, 2'b01, 0, 32'h192, 32'h0, 32'h00008001, 0, 2, 0, 0, 0);
        do_req(0, 2'b00, 1, 32'h193, 32'h0, 32'hFFFFFF80, 0, 2, 0, 0, 0);
        do_req(0, 2'b00, 0, 32'h190, 32'h0, 32'h00000044, 0, 2, 0, 0, 0);
        do_req(0, 2'b01, 1, 32'h190, 32'h0, 32'hFFFFAB44, 0, 2, 0, 0, 0);
        do_req(0, 2'b10, 1, 32'h190, 32'h0, 32'h8001AB44, 0, 2, 0, 0, 0);
        // illegal requests
        do_req(1, 2'b01, 0, 32'h193, 32'h00001234, 32'h0, 1, 1, 0, 0, 0);
        do_req(0, 2'b10, 0, 32'h196, 32'h0, 32'h0, 1, 1, 0, 0, 0);
        do_req(0, 2'b11, 0, 32'h190, 32'h0, 32'h0, 1, 1, 0, 0, 0);
        do_req(1, 2'b00, 0, 32'hFFFF0000, 32'h000000EE, 32'h0, 1, 1, 0, 0, 0);
        do_req(0, 2'b10, 0, 32'h190, 32'h0, 32'h8001AB44, 0, 2, 0, 0, 0);
        // I/O space
        do_req(1, 2'b10, 0, 32'hFFFF0000, 32'd500, 32'h0, 0, 2, 1, 32'hFFFF0000, 32'd500);
        do_req(0, 2'b10, 0, 32'hFFFF0004, 32'h0, 32'h0000CAFE, 0, 2, 0, 0, 0);

        // reset during MERGE of a byte store, with a load held through reset
        wait_ready();
        bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 32'h190; bus.req_wdata = 32'h00000055; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h190; bus.req_valid = 1'b1;
        @(negedge clk);
        chk("merge_reset_mem_we", {31'b0, bus.mem_we}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("abort_resp_err", {31'b0, bus.resp_err}, 32'h0);
        chk("abort_resp_rdata", bus.resp_rdata, 32'h0);
        chk("abort_mem_addr", bus.mem_addr, 32'h0);
        chk("abort_mem_wd", bus.mem_wd, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", {31'b0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1;
        resp_q.push_back('{32'h8001AB44, 1'b0, 2, cyc});
        bus.req_valid = 1'b0;
        wait_resp();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("final_ram_word", ram[100], 32'h8001AB44);
        chk("final_io_out", io_out, 32'd500);
        chk("resp_q_empty", resp_q.size(), 32'd0);
        chk("wr_q_empty", wr_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Byte-addressed load/store front end placed directly upstream of `dataMem`, between the CPU datapath and the word-indexed data memory / memory-mapped I/O port. It accepts one load or store per request handshake and translates byte addresses into `dataMem` word indices. It performs byte and halfword stores as a read-modify-write sequence, and returns sign- or zero-extended load data. Misaligned or illegal accesses are flagged, and no memory write occurs for them.

## Interface
- `IO_BASE`, default 32'hFFFF0000: base of the I/O region; a request is in I/O space when `req_addr[31:16] == IO_BASE[31:16]`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: a request is presented.
- `req_ready`  out  1: unit can accept; high only in IDLE.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 = byte, 01 = half, 10 = word, 11 = reserved (error).
- `req_signed`  in  1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data; byte in [7:0], half in [15:0].
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_rdata`  out  32: extended load data; 0 for stores and errors.
- `resp_err`  out  1: qualifies `resp_valid`; 1 = misaligned or illegal access.
- `mem_we`  out  1: write enable to `dataMem`.
- `mem_addr`  out  32: word index to `dataMem`.
- `mem_wd`  out  32: write data to `dataMem`.
- `mem_rd`  in  32: combinational read data from `dataMem` for the current `mem_addr`.

## Operation
- **Handshake.** A request is accepted on a clock edge where `req_valid && req_ready`. All `req_*` fields are latched at that edge. The CPU may change them afterwards.
- **Address map.**
  - RAM space: `mem_addr = {2'b00, addr[31:2]}`.
  - I/O space: `mem_addr = {addr[31:16], 2'b00, addr[15:2]}`. Byte address 0xFFFF0000 maps to word 0xFFFF0000 (outputs); 0xFFFF0004 maps to 0xFFFF0001 (inputs).
- **Byte lanes.** Little-endian: byte offset k occupies bits [8k+7:8k]; halfword offset 2 occupies [31:16].
- **Errors.** Any of the following produces an error:
  - `req_size == 11`;
  - half access with `addr[0] == 1`;
  - word access with `addr[1:0] != 0`;
  - byte or half access in I/O space.
  
  Errors make no memory access (`mem_we` stays 0), go IDLE→DONE, and give `resp_err = 1` with `resp_rdata = 0`.
- **FSM states:** IDLE, ACCESS, MERGE, DONE.
  - IDLE: `req_ready = 1`. On accept, go to ACCESS, or to DONE on error.
  - ACCESS: drives `mem_addr`.
    - Word store: `mem_we = 1`, `mem_wd = wdata`; next state DONE.
    - Load: capture `mem_rd` and select the lane by offset/size. Extend per `req_signed` (word ignores `req_signed`) into `resp_rdata`; next state DONE.
    - Sub-word store: `mem_we = 0`; capture `mem_rd` with the target lane replaced by `wdata` into the merge register; next state MERGE.
  - MERGE: `mem_we = 1`, same `mem_addr`, `mem_wd` = merge register; next state DONE.
  - DONE: `resp_valid = 1` for exactly one cycle; next state IDLE.
- **Idle outputs.** `mem_we` is 1 only in ACCESS (word store) and MERGE. In all other states `mem_addr` and `mem_wd` hold their last values.

## Timing
- **Reset values.** `reset` asserted at an edge forces the following at that edge:
  - state IDLE;
  - `resp_valid = 0`, `resp_err = 0`;
  - `resp_rdata = 0`, `mem_addr = 0`, `mem_wd = 0`.
  
  `mem_we` is gated by `!reset` combinationally, so no write is committed in a cycle where `reset` is high.
- **Reset mid-operation.** The operation is aborted. No partial write, no `resp_valid`. A sub-word store reset in MERGE leaves memory unchanged.
- **Latency from the accept edge to `resp_valid` high:**
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- **Throughput.** `req_ready` is low from the accept edge until the cycle after DONE. Back-to-back requests therefore start at most every 3 or 4 cycles. A request held high during DONE is accepted at the first IDLE edge.
- **Write commit.** The `dataMem` write commits on the rising edge that ends ACCESS (word store) or MERGE (sub-word store). A load issued immediately after a store observes the new data.
- **Simultaneous events.** `req_valid` outside IDLE is ignored and not queued. `reset` and `req_valid` asserted together: reset wins and the request is not accepted.

## Test plan
- Store word 0x11223344 at 0x190, then load word at 0x190 → one write, `mem_addr = 100`, `mem_wd = 0x11223344`; load `resp_rdata = 0x11223344`, `resp_err = 0`, 2-cycle latency each.
- Over that word, store byte 0xAB at 0x191 → ACCESS reads, MERGE writes 0x1122AB44, `mem_we` high only in MERGE. Then load byte at 0x191: signed gives 0xFFFFFFAB, unsigned gives 0x000000AB.
- Store half 0x8001 at 0x192 → memory 0x8001AB44. Load half at 0x192: signed gives 0xFFFF8001, unsigned gives 0x00008001.
- Illegal requests: half at 0x193, word at 0x196, size 11, byte at 0xFFFF0000 → each gives `resp_err = 1`, `resp_rdata = 0`, 1-cycle latency, `mem_we` never asserted, memory unchanged.
- I/O access: store word 500 at 0xFFFF0000 → `mem_addr = 0xFFFF0000`, `mem_wd = 500`. Load word at 0xFFFF0004 with `dataMem` inputs at 0xCAFE → `mem_addr = 0xFFFF0001`, `resp_rdata = 0x0000CAFE`.
- Reset: assert during MERGE of a byte store → no `mem_we`, no `resp_valid`, all outputs at reset values, word unchanged. With `req_valid` held high through reset, the first request is accepted on the edge after `reset` deasserts.
